// File: rtl/pwm_fader_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pwm_fader_pkg
//  Description : Shared types and width helpers for the pwm_fader slice.
//                Holds the per-channel ramp state encoding and the constant
//                functions that size the counters and duty registers.
//  Revision    : 1.0  initial release
// ============================================================================
package pwm_fader_pkg;

  // Ramp phase of one channel. The hold states are only reachable when
  // PWM_FADER_HOLD_EN is defined.
  typedef enum logic [1:0] {
    RISE    = 2'd0,
    HOLD_HI = 2'd1,
    FALL    = 2'd2,
    HOLD_LO = 2'd3
  } fade_state_t;

  // Bits needed to count 0..range_n-1; never less than one bit.
  function automatic int cnt_width(input int range_n);
    if (range_n <= 2) begin
      return 1;
    end
    return $clog2(range_n);
  endfunction

  // Bits needed to hold a duty value 0..pwm_interval inclusive.
  function automatic int duty_width(input int pwm_interval);
    return cnt_width(pwm_interval + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/pwm_fader_channel.sv
`default_nettype none
// ============================================================================
//  Module      : pwm_fader_channel
//  Description : One breathing-LED channel: triangle duty ramp, shadow and
//                active duty registers, PWM compare. The shadow duty moves
//                only on ramp ticks; the active duty copies it on the last
//                cycle of a PWM period so a period is never split between
//                two duty values. Optional peak/trough hold is compiled in
//                with PWM_FADER_HOLD_EN.
//  Revision    : 1.0  initial release
// ============================================================================
module pwm_fader_channel
  import pwm_fader_pkg::*;
#(
  parameter int PWM_INTERVAL = 1200,
  parameter int STEPS        = 200,
`ifdef PWM_FADER_HOLD_EN
  parameter int HOLD_STEPS   = 100,
`endif
  parameter bit START_FALL   = 1'b0
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                chan_en_i,
  input  logic                                tick_i,
  input  logic                                wrap_i,
  input  logic [duty_width(PWM_INTERVAL)-1:0] pwm_count_i,
  output logic                                pwm_o,
  output logic [duty_width(PWM_INTERVAL)-1:0] duty_o
);

  localparam int              DW         = duty_width(PWM_INTERVAL);
  localparam int              INC_INT    = PWM_INTERVAL / STEPS;
  localparam logic [DW-1:0]   INC_VAL    = DW'(INC_INT);
  localparam logic [DW-1:0]   DUTY_MAX   = DW'(STEPS * INC_INT);
  localparam fade_state_t     RST_STATE  = START_FALL ? FALL : RISE;
  localparam logic [DW-1:0]   RST_DUTY   = START_FALL ? DUTY_MAX : '0;
`ifdef PWM_FADER_HOLD_EN
  localparam fade_state_t     AFTER_RISE = HOLD_HI;
  localparam fade_state_t     AFTER_FALL = HOLD_LO;
`else
  localparam fade_state_t     AFTER_RISE = FALL;
  localparam fade_state_t     AFTER_FALL = RISE;
`endif

  fade_state_t   state_q, state_d;
  logic [DW-1:0] shadow_q, shadow_d;
  logic [DW-1:0] active_q, active_d;
  logic          pwm_q, pwm_d;
  logic          at_max, at_min;
  logic          hold_done;

  assign at_max = (shadow_q >= DUTY_MAX);
  assign at_min = (shadow_q == '0);

`ifdef PWM_FADER_HOLD_EN
  localparam int            HW        = cnt_width(HOLD_STEPS);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_STEPS - 1);

  logic [HW-1:0] hold_cnt_q, hold_cnt_d;

  assign hold_done = (hold_cnt_q == HOLD_LAST);

  // Hold counter advances on every tick spent in a hold state, clears on exit
  always_comb begin
    hold_cnt_d = hold_cnt_q;
    if (tick_i && (state_q == HOLD_HI || state_q == HOLD_LO)) begin
      hold_cnt_d = hold_done ? '0 : hold_cnt_q + 1'b1;
    end
  end

  // Hold counter register; a disabled channel sits at its reset value
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_cnt_q <= '0;
    end else if (!chan_en_i) begin
      hold_cnt_q <= '0;
    end else begin
      hold_cnt_q <= hold_cnt_d;
    end
  end
`else
  // Without hold the hold states are unreachable; leave them immediately
  assign hold_done = 1'b1;
`endif

  // State and duty registers; a disabled channel is parked at reset values
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= RST_STATE;
      shadow_q <= RST_DUTY;
      active_q <= RST_DUTY;
      pwm_q    <= 1'b0;
    end else if (!chan_en_i) begin
      state_q  <= RST_STATE;
      shadow_q <= RST_DUTY;
      active_q <= RST_DUTY;
      pwm_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      active_q <= active_d;
      pwm_q    <= pwm_d;
    end
  end

  // Ramp direction changes on the tick that finds the duty at an end stop
  always_comb begin
    state_d = state_q;
    if (tick_i) begin
      case (state_q)
        RISE:    if (at_max)    state_d = AFTER_RISE;
        FALL:    if (at_min)    state_d = AFTER_FALL;
        HOLD_HI: if (hold_done) state_d = FALL;
        HOLD_LO: if (hold_done) state_d = RISE;
        default:                state_d = RST_STATE;
      endcase
    end
  end

  // Shadow steps on ticks, active copies shadow at the period boundary,
  // PWM compares the period count against the active duty
  always_comb begin
    shadow_d = shadow_q;
    if (tick_i) begin
      if (state_q == RISE && !at_max) begin
        shadow_d = shadow_q + INC_VAL;
      end else if (state_q == FALL && !at_min) begin
        shadow_d = shadow_q - INC_VAL;
      end
    end
    active_d = wrap_i ? shadow_q : active_q;
    pwm_d    = (pwm_count_i < active_q);
  end

  assign pwm_o  = pwm_q;
  assign duty_o = active_q;

endmodule
`default_nettype wire

// File: rtl/pwm_fader.sv
`default_nettype none
// ============================================================================
//  Module      : pwm_fader
//  Description : Multi-channel LED breathing generator. A shared PWM period
//                counter and ramp-tick prescaler drive CHANNELS independent
//                fade channels. Even channels start rising from 0, odd
//                channels start falling from full duty.
//                Build option: define PWM_FADER_HOLD_EN for peak/trough hold
//                of HOLD_STEPS ticks.
//  Revision    : 1.0  initial release
// ============================================================================
module pwm_fader
  import pwm_fader_pkg::*;
#(
  parameter int CHANNELS     = 3,
  parameter int PWM_INTERVAL = 1200,
  parameter int STEPS        = 200,
  parameter int STEP_CYCLES  = 12000,
  parameter int HOLD_STEPS   = 100
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic                                         en,
  input  logic [CHANNELS-1:0]                          chan_en,
  output logic [CHANNELS-1:0]                          pwm_out,
  output logic [CHANNELS*duty_width(PWM_INTERVAL)-1:0] duty,
  output logic                                         period_start
);

  localparam int            DW        = duty_width(PWM_INTERVAL);
  localparam int            SW        = cnt_width(STEP_CYCLES);
  localparam logic [DW-1:0] PWM_LAST  = DW'(PWM_INTERVAL - 1);
  localparam logic [SW-1:0] STEP_LAST = SW'(STEP_CYCLES - 1);

  if (CHANNELS < 1 || STEPS < 1 || STEPS > PWM_INTERVAL ||
      STEP_CYCLES < 1 || HOLD_STEPS < 1) begin : g_param_check
    $error("pwm_fader: invalid parameter set");
  end

  logic [DW-1:0] pwm_count_q, pwm_count_d;
  logic [SW-1:0] step_cnt_q, step_cnt_d;
  logic          period_start_q;
  logic          wrap;
  logic          tick;

  assign wrap = (pwm_count_q == PWM_LAST);
  assign tick = en && (step_cnt_q == STEP_LAST);

  // Period counter free-runs; the prescaler only advances while en is high
  always_comb begin
    pwm_count_d = wrap ? '0 : pwm_count_q + 1'b1;
    step_cnt_d  = step_cnt_q;
    if (en) begin
      step_cnt_d = tick ? '0 : step_cnt_q + 1'b1;
    end
  end

  // Shared counters; period_start is registered to line up with pwm_out
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pwm_count_q    <= '0;
      step_cnt_q     <= '0;
      period_start_q <= 1'b0;
    end else begin
      pwm_count_q    <= pwm_count_d;
      step_cnt_q     <= step_cnt_d;
      period_start_q <= (pwm_count_q == '0);
    end
  end

  assign period_start = period_start_q;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    pwm_fader_channel #(
      .PWM_INTERVAL (PWM_INTERVAL),
      .STEPS        (STEPS),
`ifdef PWM_FADER_HOLD_EN
      .HOLD_STEPS   (HOLD_STEPS),
`endif
      .START_FALL   ((i % 2) == 1)
    ) u_chan (
      .clk          (clk),
      .rst          (rst),
      .chan_en_i    (chan_en[i]),
      .tick_i       (tick),
      .wrap_i       (wrap),
      .pwm_count_i  (pwm_count_q),
      .pwm_o        (pwm_out[i]),
      .duty_o       (duty[i*DW +: DW])
    );
  end

endmodule
`default_nettype wire

// File: tb/tb_pwm_fader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pwm_fader
//  Description : Scoreboard bench for pwm_fader. A reference model, driven by
//                the same inputs, pushes the expected outputs of every clock
//                into a queue; a monitor pops and compares on the falling
//                edge. The ramp is modelled as a lookup into the triangle
//                waveform indexed by the number of ticks a channel has seen.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_pwm_fader;

  localparam int CH   = 2;
  localparam int PI   = 8;
  localparam int ST   = 4;
  localparam int SC   = 16;
  localparam int HS   = 2;
  localparam int DW   = $clog2(PI + 1);
  localparam int INC  = PI / ST;
  localparam int DMAX = ST * INC;
`ifdef PWM_FADER_HOLD_EN
  localparam int HOLD_N = HS;
`else
  localparam int HOLD_N = 0;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             en = 1'b0;
  logic [CH-1:0]    chan_en = '1;
  logic [CH-1:0]    pwm_out;
  logic [CH*DW-1:0] duty;
  logic             period_start;

  pwm_fader #(
    .CHANNELS     (CH),
    .PWM_INTERVAL (PI),
    .STEPS        (ST),
    .STEP_CYCLES  (SC),
    .HOLD_STEPS   (HS)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .chan_en      (chan_en),
    .pwm_out      (pwm_out),
    .duty         (duty),
    .period_start (period_start)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [CH-1:0]    pwm;
    logic [CH*DW-1:0] duty;
    logic             ps;
  } obs_t;

  obs_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Triangle waveform: shadow duty after k ticks is seq[k % seq_len]
  int   seq[$];
  int   seq_len;
  int   off_odd;

  // Model state: period position, enabled-cycle phase, ticks per channel,
  // active duty per channel
  int   pc;
  int   ec;
  int   kt[CH];
  int   act[CH];

  function automatic void build_seq();
    seq = {};
    for (int d = 0; d <= DMAX; d += INC) seq.push_back(d);
    for (int h = 0; h <= HOLD_N; h++) seq.push_back(DMAX);
    for (int d = DMAX - INC; d >= 0; d -= INC) seq.push_back(d);
    for (int h = 0; h <= HOLD_N; h++) seq.push_back(0);
    // last entry is "rising from 0" again, identical to index 0
    seq_len = seq.size() - 1;
    // odd channels start at the first falling-from-peak position
    off_odd = ST + 1 + HOLD_N;
  endfunction

  function automatic int shadow_of(int ch, int k);
    return seq[(k + ((ch % 2 == 1) ? off_odd : 0)) % seq_len];
  endfunction

  function automatic int rst_duty(int ch);
    return (ch % 2 == 1) ? DMAX : 0;
  endfunction

  function automatic logic [CH*DW-1:0] rst_duty_vec();
    logic [CH*DW-1:0] v;
    v = '0;
    for (int i = 0; i < CH; i++) v[i*DW +: DW] = DW'(rst_duty(i));
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] got,
                       input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, got, want);
    end
  endtask

  // Reference model: one expected observation per rising edge
  initial begin : model
    obs_t e;
    bit   tk;
    forever begin
      @(posedge clk);
      e = '0;
      if (rst) begin
        pc = 0;
        ec = 0;
        for (int i = 0; i < CH; i++) begin
          kt[i]  = 0;
          act[i] = rst_duty(i);
        end
      end else begin
        tk   = en && (ec == SC - 1);
        e.ps = (pc == 0);
        for (int i = 0; i < CH; i++) begin
          e.pwm[i] = chan_en[i] && (pc < act[i]);
          if (!chan_en[i]) begin
            kt[i]  = 0;
            act[i] = rst_duty(i);
          end else begin
            if (pc == PI - 1) act[i] = shadow_of(i, kt[i]);
            if (tk) kt[i]++;
          end
        end
        pc = (pc + 1) % PI;
        if (en) ec = (ec + 1) % SC;
      end
      for (int i = 0; i < CH; i++) e.duty[i*DW +: DW] = act[i][DW-1:0];
      exp_q.push_back(e);
    end
  end

  // Monitor: compare DUT outputs against the scoreboard on the falling edge
  initial begin : monitor
    obs_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        n_tests++;
        if (pwm_out !== e.pwm || duty !== e.duty || period_start !== e.ps) begin
          n_fail++;
          $display("FAIL cycle t=%0t: pwm_out=%b duty=%h period_start=%b, expected pwm_out=%b duty=%h period_start=%b",
                   $time, pwm_out, duty, period_start, e.pwm, e.duty, e.ps);
        end
      end
    end
  end

  // Stimulus
  initial begin : stim
    build_seq();
    rst     = 1'b1;
    en      = 1'b0;
    chan_en = '1;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Ramps frozen: static duties, PWM running
    repeat (40) @(negedge clk);

    // Full ramps in both directions, including turn-arounds
    en = 1'b1;
    repeat (500) @(negedge clk);

    // Randomised enable and per-channel enable activity
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if ($urandom_range(0, 31) == 0) en = ~en;
      if ($urandom_range(0, 99) == 0) chan_en[$urandom_range(0, CH - 1)] ^= 1'b1;
    end

    // Asynchronous reset asserted between edges in the middle of a period
    en      = 1'b1;
    chan_en = '1;
    repeat (200 + $urandom_range(0, 7)) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_pwm_out", 32'(pwm_out), 32'(0));
    check("async_rst_period_start", 32'(period_start), 32'(0));
    check("async_rst_duty", 32'(duty), 32'(rst_duty_vec()));
    repeat (2) @(negedge clk);
    rst = 1'b0;
    en  = 1'b0;

    // Post-reset sequence as after the first release, then ramp again
    repeat (40) @(negedge clk);
    en = 1'b1;
    repeat (300) @(negedge clk);

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pwm_fader.md
# pwm_fader

Multi-channel LED breathing generator: one shared PWM period counter drives `CHANNELS` outputs, each with its own triangle-wave duty ramp, optional peak/trough hold, and glitch-free duty updates applied only at PWM period boundaries. It sits between the board clock and the LED pins as the parametrised successor of the single-channel fade PWM, replacing per-LED fade logic in top-level designs.

## Interface
- `CHANNELS`, 3, number of independent PWM outputs (≥1)
- `PWM_INTERVAL`, 1200, clk cycles per PWM period (100 µs at 12 MHz)
- `STEPS`, 200, duty increments per ramp; `INC_VAL = PWM_INTERVAL / STEPS`, `DUTY_MAX = STEPS * INC_VAL`
- `STEP_CYCLES`, 12000, clk cycles between ramp ticks (1 ms)
- `HOLD_STEPS`, 100, ticks spent in each hold state (used only with hold feature)
- `clk` input 1, system clock
- `rst` input 1, asynchronous, active-high reset
- `en` input 1, ramp enable; low freezes all ramps, PWM keeps running
- `chan_en` input CHANNELS, per-channel enable
- `pwm_out` output CHANNELS, registered PWM outputs
- `duty` output CHANNELS*$clog2(PWM_INTERVAL+1), active duty per channel, channel i at bits [i*W +: W]
- `period_start` output 1, one-cycle pulse on the first cycle of each PWM period

## Operation
- `pwm_count` runs 0..PWM_INTERVAL-1, wraps to 0; free-running regardless of `en`.
- `step_cnt` runs 0..STEP_CYCLES-1 only while `en`=1, holds when `en`=0; `tick` = `en` && `step_cnt`==STEP_CYCLES-1.
- Per channel: `shadow` duty and `active` duty. `shadow` changes on `tick` only; `active` loads `shadow` when `pwm_count`==PWM_INTERVAL-1.
- Channel states: RISE, HOLD_HI, FALL, HOLD_LO. On `tick`:
  - RISE: `shadow`<DUTY_MAX → `shadow`+=INC_VAL; else → HOLD_HI (→ FALL without hold), duty unchanged.
  - FALL: `shadow`>0 → `shadow`-=INC_VAL; else → HOLD_LO (→ RISE without hold), duty unchanged.
  - HOLD_x: `hold_cnt`++; on HOLD_STEPS-th tick → FALL/RISE, `hold_cnt` cleared.
- Reset/disabled values: even channels RISE, `shadow`=`active`=0; odd channels FALL, `shadow`=`active`=DUTY_MAX; `hold_cnt`=0.
- `chan_en[i]`=0: channel i held at its reset values, `pwm_out[i]`=0; resumes from reset values when re-enabled.
- `pwm_out[i]` next = `chan_en[i]` && (`pwm_count` < `active[i]`): duty 0 → always low, DUTY_MAX=PWM_INTERVAL → always high.
- Arithmetic: duty never leaves [0, DUTY_MAX]; counters are `$clog2` wide, no overflow.

## Timing
- Reset: all counters 0, `pwm_out`=0, `period_start`=0, `duty` = channel reset values, immediately on `rst` assertion (async).
- `pwm_out` and `period_start` lag `pwm_count` by one cycle.
- `tick` and period wrap in same cycle: `active` loads the pre-tick `shadow`; new value applies next period.
- `en` falling mid-period: current `active` continues; no ticks until `en` rises; `step_cnt` resumes from held value.
- `rst` mid-ramp: all state returns to reset values asynchronously; first tick STEP_CYCLES cycles after release.

## Configuration
- `PWM_FADER_HOLD_EN` defined: four-state ramp with HOLD_HI/HOLD_LO, each lasting HOLD_STEPS ticks.
- Undefined: two-state ramp RISE↔FALL, `hold_cnt` and HOLD_STEPS logic absent; HOLD_STEPS ignored.

## Structure
- `pwm_fader_pkg`: `fade_state_t` enum (RISE, HOLD_HI, FALL, HOLD_LO), width helper constant functions.
- Sub-module `pwm_fader_channel`: state machine, shadow/active duty, hold counter, output compare; instantiated CHANNELS times via generate. Top holds `pwm_count`, `step_cnt`, `tick`, `period_start`.

## Test plan
Parameters CHANNELS=2, PWM_INTERVAL=8, STEPS=4 (INC_VAL=2, DUTY_MAX=8), STEP_CYCLES=16, HOLD_STEPS=2:
- Reset release, `chan_en`=2'b11, `en`=0 → `duty0`=0, `duty1`=8; `pwm_out[1]` high 8/8 cycles, `pwm_out[0]` low; `period_start` every 8 cycles.
- `en`=1 → `duty0` steps 0,2,4,6,8 each 16 cycles, each change landing on a period boundary; at duty 2 `pwm_out[0]` high 2 of 8 cycles.
- Hold on: `duty0` at 8 → transition tick + 2 hold ticks at 8, then 6; hold off: next tick after transition gives 6; `duty1` mirrors (falls to 0, holds, rises).
- `en`=0 mid-ramp at duty 4 for 100 cycles → `duty0` stays 4, PWM unchanged; `en`=1 → next tick after remaining `step_cnt` gives 6.
- `chan_en[0]`=0 at duty 6 → `pwm_out[0]`=0 next cycle, `duty0`=0; re-enable → rises from 0.
- `rst` pulsed between clk edges mid-period → `pwm_out`=0, `period_start`=0 immediately; post-release sequence matches first scenario.
